ntt_sched: RTL

NTT_SCHED -- requirements
Module: ntt_sched

---
 rtl/ntt_sched_if.sv | 48 ++++
 rtl/ntt_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ntt_sched_if.sv
// ntt_sched_if -- handshake bundle between the NTT stage scheduler and its
// environment (AGU, butterfly memory banks, host control).
//
// Signals
//   start       host -> sched   one-cycle request to run a full transform
//   abort       host -> sched   cancel the transform in progress
//   agu_out_en  agu  -> sched   address-valid strobe
//   agu_done    agu  -> sched   end-of-transform pulse
//   agu_l       agu  -> sched   stage index the AGU is currently walking
//   agu_enable  sched -> agu    enable for the address generator
//   rd_en       sched -> banks  read strobe
//   wr_en       sched -> banks  write-back strobe, read strobe delayed by
//                               the butterfly pipeline latency
//   bank_sel    sched -> banks  ping-pong source-bank select
//   stage       sched -> host   current stage index
//   busy        sched -> host   transform in progress
//   done        sched -> host   one-cycle completion pulse
//   err         sched -> host   sticky protocol-error flag
//
// Modports: slave is the scheduler side, master is the environment side.

interface ntt_sched_if #(
    parameter int D_WIDTH = 16
);
    logic               start;
    logic               abort;
    logic               agu_out_en;
    logic               agu_done;
    logic [D_WIDTH-1:0] agu_l;
    logic               agu_enable;
    logic               rd_en;
    logic               wr_en;
    logic               bank_sel;
    logic [D_WIDTH-1:0] stage;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, abort, agu_out_en, agu_done, agu_l,
        input  agu_enable, rd_en, wr_en, bank_sel, stage, busy, done, err
    );

    modport slave (
        input  start, abort, agu_out_en, agu_done, agu_l,
        output agu_enable, rd_en, wr_en, bank_sel, stage, busy, done, err
    );
endinterface

// File: rtl/ntt_sched.sv
// ntt_sched -- stage scheduler for a K-stage radix-2^RADIX_K1 NTT.
//
// Sequences K stages over a ping-pong bank pair. Each stage enables the AGU
// for 2^(LOGN-RADIX_K1) cycles, then drains the butterfly pipeline for
// PIPE_LAT+1 cycles so the last write-back of the stage retires before the
// bank roles swap. Read strobes follow the AGU address-valid strobe; write
// strobes are the read strobes delayed by PIPE_LAT cycles. AGU protocol
// violations raise a sticky err flag.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    ntt_sched_if.slave (see interface header for signal list)
//
// State table
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; stage/bank_sel hold their last values
//   S_RUN   | AGU enabled, counting the butterfly issue cycles of a stage
//   S_DRAIN | AGU disabled, waiting for the pipeline to retire writes
//   S_DONE  | one-cycle completion pulse, then back to idle

module ntt_sched #(
    parameter int LOGN     = 12,
    parameter int RADIX_K1 = 4,
    parameter int K        = 3,
    parameter int PIPE_LAT = 4,
    parameter int D_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    ntt_sched_if.slave  bus
);

    localparam int RUN_W   = LOGN - RADIX_K1;
    localparam int RUN_CYC = 1 << RUN_W;
    // One spare bit above the larger of the two terminal counts.
    localparam int CNT_W   = ((RUN_W > 4) ? RUN_W : 4) + 1;

    localparam logic [CNT_W-1:0]   RUN_LAST   = CNT_W'(RUN_CYC - 1);
    localparam logic [CNT_W-1:0]   DRAIN_LAST = CNT_W'(PIPE_LAT);
    localparam logic [D_WIDTH-1:0] STAGE_LAST = D_WIDTH'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [D_WIDTH-1:0]   stage_q, stage_d;
    logic                 bank_q, bank_d;
    logic                 err_q, err_d;
    logic [PIPE_LAT-1:0]  sr_q, sr_d;

    logic                 agu_enable;
    logic                 busy;
    logic                 done;
    logic                 rd_en;
    logic                 start_acc;
    logic                 first_drain_last;
    logic                 viol;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            bank_q  <= 1'b0;
            err_q   <= 1'b0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            bank_q  <= bank_d;
            err_q   <= err_d;
            sr_q    <= sr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = (stage_q == STAGE_LAST) ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every other transition.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        start_acc = (state_q == S_IDLE) && bus.start;

        // The counter restarts from zero on every state change, so one
        // counter serves both the RUN length and the DRAIN length.
        if ((state_d == state_q) && (state_q inside {S_RUN, S_DRAIN})) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end

        stage_d = stage_q;
        bank_d  = bank_q;
        if (start_acc) begin
            stage_d = '0;
            bank_d  = 1'b0;
        end else if ((state_q == S_DRAIN) && (state_d == S_RUN)) begin
            stage_d = stage_q + 1'b1;
            bank_d  = ~bank_q;
        end

        // The AGU must report done exactly on the first drain cycle of the
        // last stage, and never anywhere else.
        first_drain_last = (state_q == S_DRAIN) && (cnt_q == '0) &&
                           (stage_q == STAGE_LAST);
        viol = ((state_q == S_RUN) && (bus.agu_l != stage_q)) ||
               (bus.agu_done != first_drain_last);

        if (start_acc) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q | viol;
        end

        // Write-strobe delay line; abort flushes in-flight strobes.
        sr_d = '0;
        if (!bus.abort) begin
            sr_d[0] = rd_en;
            for (int i = 1; i < PIPE_LAT; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        agu_enable = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state_q)
            S_IDLE:  busy       = 1'b0;
            S_RUN:   agu_enable = 1'b1;
            S_DONE:  done       = 1'b1;
            default: ;
        endcase
        rd_en = bus.agu_out_en & busy;
    end

    assign bus.agu_enable = agu_enable;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.rd_en      = rd_en;
    assign bus.wr_en      = sr_q[PIPE_LAT-1];
    assign bus.bank_sel   = bank_q;
    assign bus.stage      = stage_q;
    assign bus.err        = err_q;

endmodule
